// File: rtl/editor_campos_rtc_pkg.sv
// editor_campos_rtc_pkg (rtc_defs)
//   Shared definitions for the RTC field editor: edit-mode codes as driven by
//   the display FSM, cursor codes, editor FSM states, fixed BCD field limits
//   and a small BCD conversion helper used to turn integer parameters into
//   BCD limits at elaboration time.
package editor_campos_rtc_pkg;

    typedef enum logic [1:0] {
        MODO_NONE  = 2'b00,
        MODO_TIMER = 2'b01,
        MODO_FECHA = 2'b10,
        MODO_HORA  = 2'b11
    } modo_t;

    typedef enum logic [1:0] {
        POS_NONE = 2'b00,
        POS_C2   = 2'b01,
        POS_C1   = 2'b10,
        POS_C0   = 2'b11
    } pos_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EDIT,
        ST_COMMIT
    } estado_t;

    localparam logic [7:0] BCD_00       = 8'h00;
    localparam logic [7:0] BCD_01       = 8'h01;
    localparam logic [7:0] HORA_MAX     = 8'h23;
    localparam logic [7:0] MIN_SEG_MAX  = 8'h59;
    localparam logic [7:0] MES_MAX      = 8'h12;

    // Two-digit BCD encoding of 0..99; larger values keep only the low two digits.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] decenas;
        logic [3:0] unidades;
        decenas  = 4'((v / 10) % 10);
        unidades = 4'(v % 10);
        return {decenas, unidades};
    endfunction

endpackage

// File: rtl/editor_campos_rtc_bcd_paso.sv
// bcd_paso
//   Combinational single-step of a two-digit BCD field inside [min, max].
//   Ports:
//     val      in  8  current BCD value
//     min      in  8  lowest legal BCD value of the field
//     max      in  8  highest legal BCD value of the field
//     up       in  1  increment request
//     down     in  1  decrement request
//     next_val out 8  stepped value (val when no step or both requests)
//   An out-of-range or non-BCD value snaps to min on any step so the field
//   is legal from the first press onwards.
module bcd_paso (
    input  logic [7:0] val,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next_val
);

    logic legal;

    // For valid BCD the unsigned byte compare orders values like decimals.
    assign legal = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) &&
                   (val >= min) && (val <= max);

    always_comb begin
        next_val = val;
        if (up ^ down) begin
            if (!legal) begin
                next_val = min;
            end else if (up) begin
                if (val == max)
                    next_val = min;
                else if (val[3:0] == 4'd9)
                    next_val = {val[7:4] + 4'd1, 4'd0};
                else
                    next_val = {val[7:4], val[3:0] + 4'd1};
            end else begin
                if (val == min)
                    next_val = max;
                else if (val[3:0] == 4'd0)
                    next_val = {val[7:4] - 4'd1, 4'd9};
                else
                    next_val = {val[7:4], val[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/editor_campos_rtc.sv
// editor_campos_rtc
//   Edits the three BCD fields of the RTC register set selected by the
//   display edit FSM. Entering an edit mode loads the fields from the RTC,
//   button presses step the field under the cursor with wrap-around, and
//   leaving the mode (or switching to another one) emits a one-cycle write
//   strobe tagged with the mode that was being edited.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     FSMedit[1:0]        edit mode: 00 none, 01 timer, 10 fecha, 11 hora
//     FSMpos[1:0]         cursor: 11 field0, 10 field1, 01 field2, 00 none
//     boton_up/down       raw button levels
//     rtc_c0..rtc_c2      current BCD field values from the RTC
//     campo0..campo2      edited BCD field values
//     editando            high while editing
//     wr_en, wr_sel[1:0]  one-cycle commit strobe and the mode it belongs to
module editor_campos_rtc
    import editor_campos_rtc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIA_MAX     = 31,
    parameter int ANIO_MAX    = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] FSMedit,
    input  logic [1:0] FSMpos,
    input  logic       boton_up,
    input  logic       boton_down,
    input  logic [7:0] rtc_c0,
    input  logic [7:0] rtc_c1,
    input  logic [7:0] rtc_c2,
    output logic [7:0] campo0,
    output logic [7:0] campo1,
    output logic [7:0] campo2,
    output logic       editando,
    output logic       wr_en,
    output logic [1:0] wr_sel
);

    localparam logic [7:0] DIA_MAX_BCD  = to_bcd(DIA_MAX);
    localparam logic [7:0] ANIO_MAX_BCD = to_bcd(ANIO_MAX);

    logic [SYNC_STAGES-1:0] up_sync_p0;
    logic [SYNC_STAGES-1:0] dn_sync_p0;
    logic                   up_prev_p1;
    logic                   dn_prev_p1;
    logic                   up_edge;
    logic                   dn_edge;

    estado_t    state;
    estado_t    state_next;
    logic [1:0] modo_reg;
    logic       load_en;
    logic       step_en;

    logic [7:0] min0, max0, min1, max1, min2, max2;
    logic [7:0] sel_val, sel_min, sel_max;
    logic       sel_ok;
    logic [7:0] paso_val;

    // Stage p0: button synchronizers; stage p1: previous level for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_sync_p0 <= '0;
            dn_sync_p0 <= '0;
            up_prev_p1 <= 1'b0;
            dn_prev_p1 <= 1'b0;
        end else begin
            up_sync_p0 <= {up_sync_p0[SYNC_STAGES-2:0], boton_up};
            dn_sync_p0 <= {dn_sync_p0[SYNC_STAGES-2:0], boton_down};
            up_prev_p1 <= up_sync_p0[SYNC_STAGES-1];
            dn_prev_p1 <= dn_sync_p0[SYNC_STAGES-1];
        end
    end

    assign up_edge = up_sync_p0[SYNC_STAGES-1] & ~up_prev_p1;
    assign dn_edge = dn_sync_p0[SYNC_STAGES-1] & ~dn_prev_p1;

    // Editor FSM state and captured mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            modo_reg <= MODO_NONE;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && FSMedit != MODO_NONE)
                modo_reg <= FSMedit;
        end
    end

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        step_en    = 1'b0;
        editando   = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = 2'b00;
        case (state)
            ST_IDLE: begin
                if (FSMedit != MODO_NONE)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load_en    = 1'b1;
                state_next = ST_EDIT;
            end
            ST_EDIT: begin
                editando = 1'b1;
                // Leaving to 00 or to a different mode both commit the old mode first.
                if (FSMedit != modo_reg)
                    state_next = ST_COMMIT;
                else
                    step_en = 1'b1;
            end
            ST_COMMIT: begin
                wr_en      = 1'b1;
                wr_sel     = modo_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Field limits for the mode being edited (timer shares the hora ranges)
    always_comb begin
        min0 = BCD_00;
        max0 = HORA_MAX;
        min1 = BCD_00;
        max1 = MIN_SEG_MAX;
        min2 = BCD_00;
        max2 = MIN_SEG_MAX;
        if (modo_reg == MODO_FECHA) begin
            min0 = BCD_01;
            max0 = DIA_MAX_BCD;
            min1 = BCD_01;
            max1 = MES_MAX;
            min2 = BCD_00;
            max2 = ANIO_MAX_BCD;
        end
    end

    // Cursor selects which field feeds the shared stepper
    always_comb begin
        sel_val = campo0;
        sel_min = min0;
        sel_max = max0;
        sel_ok  = 1'b0;
        case (FSMpos)
            POS_C0: begin
                sel_val = campo0; sel_min = min0; sel_max = max0; sel_ok = 1'b1;
            end
            POS_C1: begin
                sel_val = campo1; sel_min = min1; sel_max = max1; sel_ok = 1'b1;
            end
            POS_C2: begin
                sel_val = campo2; sel_min = min2; sel_max = max2; sel_ok = 1'b1;
            end
            default: sel_ok = 1'b0;
        endcase
    end

    bcd_paso u_bcd_paso (
        .val      (sel_val),
        .min      (sel_min),
        .max      (sel_max),
        .up       (up_edge),
        .down     (dn_edge),
        .next_val (paso_val)
    );

    // Field registers: load on entry, step while editing, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            campo0 <= 8'h00;
            campo1 <= 8'h00;
            campo2 <= 8'h00;
        end else if (load_en) begin
            campo0 <= rtc_c0;
            campo1 <= rtc_c1;
            campo2 <= rtc_c2;
        end else if (step_en && sel_ok) begin
            case (FSMpos)
                POS_C0:  campo0 <= paso_val;
                POS_C1:  campo1 <= paso_val;
                POS_C2:  campo2 <= paso_val;
                default: ;
            endcase
        end
    end

endmodule
